// File: rtl/cache_rd_arbiter.sv
// Shares one AXI read channel between ICache/DCache refills: grant, one INCR burst per line, single-cycle line return.
// Latency 6 cycles best case; AR/R stalls stretch it; losers wait in IDLE. `CACHE_ARB_RR_EN selects round-robin ties.
module cache_rd_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ID_W       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      icache_rd_req,
  input  logic [31:0]               icache_rd_addr,
  output logic                      icache_rd_rdy,
  output logic                      icache_ret_valid,
  output logic [32*LINE_WORDS-1:0]  icache_ret_data,
  input  logic                      dcache_rd_req,
  input  logic [31:0]               dcache_rd_addr,
  output logic                      dcache_rd_rdy,
  output logic                      dcache_ret_valid,
  output logic [32*LINE_WORDS-1:0]  dcache_ret_data,
  output logic [ID_W-1:0]           arid,
  output logic [31:0]               araddr,
  output logic [7:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [ID_W-1:0]           rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                        state, state_nxt;
  logic                          owner;      // 1 = DCache
  logic [31:0]                   addr_q;
  logic [CW-1:0]                 beat_cnt;
  logic [LINE_WORDS-1:0][31:0]   line_buf;
  logic                          grant;
  logic                          grant_d;
  logic                          unused_axi;

  assign unused_axi = ^{rid, rresp, rlast};
  assign grant      = (state == IDLE) && (icache_rd_req || dcache_rd_req);

`ifdef CACHE_ARB_RR_EN
  logic last_owner;

  // On a tie the requester that did not win last time goes first.
  assign grant_d = dcache_rd_req && (!icache_rd_req || !last_owner);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= 1'b0;
    end else if (grant) begin
      last_owner <= grant_d;
    end
  end
`else
  assign grant_d = dcache_rd_req;
`endif

  always_comb begin
    state_nxt        = state;
    icache_rd_rdy    = 1'b0;
    dcache_rd_rdy    = 1'b0;
    icache_ret_valid = 1'b0;
    dcache_ret_valid = 1'b0;
    arvalid          = 1'b0;
    arlen            = '0;
    arsize           = '0;
    arburst          = '0;
    rready           = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          icache_rd_rdy = !grant_d;
          dcache_rd_rdy = grant_d;
          state_nxt     = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        arlen   = 8'(LINE_WORDS - 1);
        arsize  = 3'b010;
        arburst = 2'b01;
        if (arready) state_nxt = DATA;
      end
      DATA: begin
        rready = 1'b1;
        if (rvalid && beat_cnt == LAST_BEAT) state_nxt = DONE;
      end
      DONE: begin
        icache_ret_valid = !owner;
        dcache_ret_valid = owner;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      addr_q   <= '0;
      beat_cnt <= '0;
      line_buf <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner    <= grant_d;
        addr_q   <= grant_d ? dcache_rd_addr : icache_rd_addr;
        beat_cnt <= '0;
      end
      if (state == DATA && rvalid) begin
        line_buf[beat_cnt] <= rdata;
        beat_cnt           <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CW'(1);
      end
    end
  end

  assign araddr          = addr_q;
  assign arid            = ID_W'(owner);
  assign icache_ret_data = line_buf;
  assign dcache_ret_data = line_buf;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Bench for cache_rd_arbiter: directed scenarios plus random traffic checked every cycle
// against a timestamp-based transaction model of grants, AR/R phases and line returns.
module tb_cache_rd_arbiter;
  localparam int LW  = 4;
  localparam int IDW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              icache_rd_req, dcache_rd_req;
  logic [31:0]       icache_rd_addr, dcache_rd_addr;
  logic              icache_rd_rdy, dcache_rd_rdy;
  logic              icache_ret_valid, dcache_ret_valid;
  logic [32*LW-1:0]  icache_ret_data, dcache_ret_data;
  logic [IDW-1:0]    arid, rid;
  logic [31:0]       araddr, rdata;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst, rresp;
  logic              arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  cache_rd_arbiter #(.LINE_WORDS(LW), .ID_W(IDW)) dut (
    .clk(clk), .reset(reset),
    .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr), .icache_rd_rdy(icache_rd_rdy),
    .icache_ret_valid(icache_ret_valid), .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr), .dcache_rd_rdy(dcache_rd_rdy),
    .dcache_ret_valid(dcache_ret_valid), .dcache_ret_data(dcache_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: one in-flight refill described by timestamps.
  int          cyc = 0;
  bit          act = 0;
  bit          own;
  int          t_grant, t_ar, t_last, ret_t;
  int          nbeats;
  logic [31:0] exp_addr;
  logic [31:0] words [LW];
  logic [127:0] last_line;
  bit          last_owner = 0;
  bit          wait_r [2] = '{0, 0};
  logic [31:0] raddr [2];
  bit          grant_log [$];
  int          grant_t_log [$];
  int          ret_log [$];

  // Stimulus knobs.
  bit          auto_req  = 0;
  int          req_prob  = 30;
  int          stall_cfg = 0;
  int          stall_left = 0;
  bit          use_fixed = 0;
  logic [31:0] dbase = '0;
  bit          vpat [$];

  task automatic run_cycle(input bit rst_now);
    bit exp_arv, exp_dat, exp_ret, free, any, w, vdrv;
    logic [127:0] line;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst_now;
    if (auto_req && !rst_now) begin
      for (int c = 0; c < 2; c++) begin
        if (!wait_r[c] && !(act && own == c[0]) && $urandom_range(0, 99) < req_prob) begin
          wait_r[c] = 1;
          raddr[c]  = $urandom & 32'hFFFF_FFF0;
        end
      end
    end
    exp_arv = !rst_now && act && cyc > t_grant && t_ar < 0;
    exp_dat = !rst_now && act && t_ar >= 0 && cyc > t_ar && nbeats < LW;
    icache_rd_req  = !rst_now && wait_r[0];
    dcache_rd_req  = !rst_now && wait_r[1];
    icache_rd_addr = raddr[0];
    dcache_rd_addr = raddr[1];
    arready = exp_arv && stall_left == 0;
    if (exp_arv && stall_left > 0) stall_left--;
    vdrv = 0;
    if (exp_dat) vdrv = (vpat.size() > 0) ? vpat.pop_front() : ($urandom_range(0, 2) != 0);
    rvalid = vdrv;
    rdata  = use_fixed ? dbase + 32'(nbeats) : $urandom;
    rid    = IDW'($urandom);
    rresp  = 2'($urandom);
    rlast  = 1'($urandom);
    @(negedge clk);
    if (rst_now) begin
      act = 0; wait_r[0] = 0; wait_r[1] = 0; last_owner = 0;
      vpat.delete();
      return;
    end
    free = !act;
    any  = wait_r[0] || wait_r[1];
    w    = wait_r[1];
    if (wait_r[0] && wait_r[1]) begin
`ifdef CACHE_ARB_RR_EN
      w = !last_owner;
`else
      w = 1;
`endif
    end
    check_eq("icache_rd_rdy", 128'(icache_rd_rdy), 128'(free && any && !w));
    check_eq("dcache_rd_rdy", 128'(dcache_rd_rdy), 128'(free && any && w));
    check_eq("arvalid", 128'(arvalid), 128'(exp_arv));
    if (exp_arv)
      check_eq("ar_fields", 128'({araddr, arid, arlen, arsize, arburst}),
               128'({exp_addr, IDW'(own), 8'(LW - 1), 3'b010, 2'b01}));
    check_eq("rready", 128'(rready), 128'(exp_dat));
    exp_ret = act && nbeats == LW && cyc == t_last + 1;
    check_eq("icache_ret_valid", 128'(icache_ret_valid), 128'(exp_ret && !own));
    check_eq("dcache_ret_valid", 128'(dcache_ret_valid), 128'(exp_ret && own));
    if (exp_ret) begin
      for (int i = 0; i < LW; i++) line[32*i +: 32] = words[i];
      last_line = own ? dcache_ret_data : icache_ret_data;
      check_eq("ret_data", last_line, line);
      act = 0;
      ret_t = cyc;
      ret_log.push_back(cyc);
    end
    if (free && any) begin
      act = 1; own = w; t_grant = cyc; t_ar = -1; nbeats = 0;
      exp_addr = raddr[w];
      wait_r[w] = 0;
      last_owner = w;
      grant_log.push_back(w);
      grant_t_log.push_back(cyc);
      stall_left = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
    end
    if (exp_arv && arready) t_ar = cyc;
    if (exp_dat && vdrv) begin
      words[nbeats] = rdata;
      nbeats++;
      if (nbeats == LW) t_last = cyc;
    end
  endtask

  task automatic run_until_idle(input string tag, input int maxc);
    int n = 0;
    do begin
      run_cycle(0);
      n++;
    end while ((act || wait_r[0] || wait_r[1]) && n < maxc);
    check_eq({tag, "_done"}, 128'(act || wait_r[0] || wait_r[1]), 128'(0));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_ctl"}, 128'({icache_rd_rdy, dcache_rd_rdy, icache_ret_valid, dcache_ret_valid,
                                 arvalid, rready, arid, araddr, arlen, arsize, arburst}), 128'(0));
    check_eq({tag, "_data"}, icache_ret_data | dcache_ret_data, 128'(0));
  endtask

  task automatic fixed_refill(input int c, input logic [31:0] a, input logic [31:0] base,
                              input int stall);
    use_fixed = 1; dbase = base; stall_cfg = stall;
    wait_r[c] = 1; raddr[c] = a;
  endtask

  initial begin
    bit [5:0] order;
    reset = 1; icache_rd_req = 0; dcache_rd_req = 0; icache_rd_addr = '0; dcache_rd_addr = '0;
    arready = 0; rvalid = 0; rdata = '0; rid = '0; rresp = '0; rlast = 0;
    run_cycle(1);
    run_cycle(1);
    run_cycle(0);
    check_zero("reset");

    // Single ICache refill, no stalls or gaps.
    fixed_refill(0, 32'h1FC0_0040, 32'hA0, 0);
    repeat (LW) vpat.push_back(1);
    run_until_idle("single", 40);
    check_eq("single_latency", 128'(ret_t - t_grant), 128'(6));
    check_eq("single_line", last_line, 128'h000000A3_000000A2_000000A1_000000A0);
    check_eq("single_owner", 128'(grant_log[grant_log.size()-1]), 128'(0));

    // Three simultaneous-request rounds.
    grant_log.delete(); grant_t_log.delete(); ret_log.delete();
    use_fixed = 0;
    for (int r = 0; r < 3; r++) begin
      wait_r[0] = 1; raddr[0] = 32'h0000_1000 + 32'(r * 16);
      wait_r[1] = 1; raddr[1] = 32'h8000_2000 + 32'(r * 16);
      run_until_idle("tie", 100);
    end
    order = '0;
    for (int i = 0; i < 6; i++) order = {order[4:0], grant_log[i]};
    check_eq("tie_order", 128'(order), 128'(6'b101010));
    for (int r = 0; r < 3; r++)
      check_eq("tie_next_grant", 128'(grant_t_log[2*r+1]), 128'(ret_log[2*r] + 1));

    // Lone DCache refill followed by a tie: only round-robin hands it to the ICache.
    grant_log.delete();
    wait_r[1] = 1; raddr[1] = 32'h0000_3000;
    run_until_idle("rr_pre", 60);
    wait_r[0] = 1; raddr[0] = 32'h0000_4000;
    wait_r[1] = 1; raddr[1] = 32'h0000_5000;
    run_until_idle("rr_tie", 100);
`ifdef CACHE_ARB_RR_EN
    check_eq("rr_winner", 128'(grant_log[1]), 128'(0));
`else
    check_eq("rr_winner", 128'(grant_log[1]), 128'(1));
`endif

    // Address stall of five cycles.
    fixed_refill(1, 32'h0000_6040, 32'hD0, 5);
    repeat (LW) vpat.push_back(1);
    run_until_idle("stall", 60);
    check_eq("stall_latency", 128'(ret_t - t_grant), 128'(11));
    check_eq("stall_line", last_line, 128'h000000D3_000000D2_000000D1_000000D0);

    // Gapped data beats.
    fixed_refill(0, 32'h0000_7080, 32'hB0, 0);
    vpat = '{1, 0, 0, 1, 1, 0, 1};
    run_until_idle("gaps", 60);
    check_eq("gaps_latency", 128'(ret_t - t_grant), 128'(9));
    check_eq("gaps_line", last_line, 128'h000000B3_000000B2_000000B1_000000B0);

    // Reset after two beats, then a fresh refill.
    fixed_refill(0, 32'h0000_90C0, 32'hE0, 0);
    vpat = '{1, 1};
    for (int n = 0; n < 20 && !(act && nbeats == 2); n++) run_cycle(0);
    check_eq("midrst_beats", 128'(nbeats), 128'(2));
    run_cycle(1);
    run_cycle(0);
    check_zero("midrst");
    fixed_refill(0, 32'h0000_A000, 32'hC0, 0);
    repeat (LW) vpat.push_back(1);
    run_until_idle("post_rst", 40);
    check_eq("post_rst_latency", 128'(ret_t - t_grant), 128'(6));
    check_eq("post_rst_line", last_line, 128'h000000C3_000000C2_000000C1_000000C0);

    // Random traffic with random AR stalls and R gaps.
    use_fixed = 0; stall_cfg = -1; auto_req = 1;
    repeat (3000) run_cycle(0);
    auto_req = 0;
    run_until_idle("drain", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
